// File: rtl/routine_bus_sink_pkg.sv
// routine_bus_sink_pkg: bus layout constants and FSM state encoding for the routine bus sink
package routine_bus_sink_pkg;
    localparam int BUS_W   = 46;
    localparam int LED_HI  = 45;
    localparam int LED_LO  = 28;
    localparam int HEX3_LO = 21;
    localparam int HEX2_LO = 14;
    localparam int HEX1_LO = 7;
    localparam int HEX0_LO = 0;
    typedef enum logic [1:0] {
        DISPLAY  = 2'd0,
        DEBOUNCE = 2'd1,
        BLANK    = 2'd2
    } state_t;
endpackage

// File: rtl/routine_bus_sink_select_sync.sv
// routine_bus_sink_select_sync: 2-flop synchroniser for the select switches plus range check
//   Clock, Reset (sync, active-low), SelectIn (raw switches)
//   sync_sel (synchronised select), sel_valid (sync_sel < NUM_ROUTINES)
module routine_bus_sink_select_sync #(
    parameter int NUM_ROUTINES = 4,
    parameter int SEL_W        = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [SEL_W-1:0] SelectIn,
    output logic [SEL_W-1:0] sync_sel,
    output logic             sel_valid
);
    logic [SEL_W-1:0] meta;
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            meta     <= '0;
            sync_sel <= '0;
        end else begin
            meta     <= SelectIn;
            sync_sel <= meta;
        end
    end
    assign sel_valid = 32'(sync_sel) < NUM_ROUTINES;
endmodule

// File: rtl/routine_bus_sink.sv
// routine_bus_sink: selects one routine bus via debounced switches, blanks on switch-over, latches per frame
//   Clock, Reset (sync, active-low), RoutineBuses (46 bits per routine), SelectIn (raw switches),
//   FrameTick (latch strobe) -> Ledr, Hex3..Hex0 (unpacked frame), ActiveRoutine, Switching (in BLANK)
module routine_bus_sink
    import routine_bus_sink_pkg::*;
#(
    parameter int NUM_ROUTINES    = 4,
    parameter int SEL_W           = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BLANK_CYCLES    = 8,
    parameter bit HEX_INVERT      = 1'b0
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic [BUS_W*NUM_ROUTINES-1:0] RoutineBuses,
    input  logic [SEL_W-1:0]              SelectIn,
    input  logic                          FrameTick,
    output logic [17:0]                   Ledr,
    output logic [6:0]                    Hex3,
    output logic [6:0]                    Hex2,
    output logic [6:0]                    Hex1,
    output logic [6:0]                    Hex0,
    output logic [SEL_W-1:0]              ActiveRoutine,
    output logic                          Switching
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int BW = $clog2(BLANK_CYCLES) + 1;
    localparam logic [6:0] HMASK = HEX_INVERT ? 7'h7F : 7'h00;
    state_t           state, state_n;
    logic [SEL_W-1:0] active, active_n, cand, cand_n, sync_sel;
    logic [CW-1:0]    cnt, cnt_n;
    logic [BW-1:0]    bcnt, bcnt_n;
    logic [BUS_W-1:0] frame, frame_n;
    logic [BUS_W-1:0] buses [NUM_ROUTINES];
    logic             sw, sw_n, sel_valid, change;
    for (genvar k = 0; k < NUM_ROUTINES; k++) begin : g_bus
        assign buses[k] = RoutineBuses[k*BUS_W +: BUS_W];
    end
    routine_bus_sink_select_sync #(.NUM_ROUTINES(NUM_ROUTINES), .SEL_W(SEL_W)) u_sync (
        .Clock    (Clock),
        .Reset    (Reset),
        .SelectIn (SelectIn),
        .sync_sel (sync_sel),
        .sel_valid(sel_valid)
    );
    // An out-of-range select counts as "no change requested".
    assign change = sel_valid && sync_sel != active;
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state  <= DISPLAY;
            active <= '0;
            cand   <= '0;
            cnt    <= '0;
            bcnt   <= '0;
            frame  <= '0;
            sw     <= 1'b0;
        end else begin
            state  <= state_n;
            active <= active_n;
            cand   <= cand_n;
            cnt    <= cnt_n;
            bcnt   <= bcnt_n;
            frame  <= frame_n;
            sw     <= sw_n;
        end
    end
    always_comb begin
        state_n  = state;
        active_n = active;
        cand_n   = cand;
        cnt_n    = cnt;
        bcnt_n   = bcnt;
        frame_n  = frame;
        sw_n     = sw;
        case (state)
            DISPLAY: begin
                if (FrameTick) frame_n = buses[active];
                if (change) begin
                    cand_n  = sync_sel;
                    cnt_n   = '0;
                    state_n = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                // The old routine keeps updating until the new one is accepted.
                if (FrameTick) frame_n = buses[active];
                if (!change) state_n = DISPLAY;
                else if (sync_sel != cand) begin
                    cand_n = sync_sel;
                    cnt_n  = '0;
                end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    // Blanking overrides any FrameTick in this cycle.
                    active_n = cand;
                    frame_n  = '0;
                    sw_n     = 1'b1;
                    bcnt_n   = '0;
                    state_n  = BLANK;
                end else cnt_n = cnt + 1'b1;
            end
            default: begin
                bcnt_n = bcnt + 1'b1;
                if (bcnt == BW'(BLANK_CYCLES - 1)) begin
                    sw_n    = 1'b0;
                    state_n = DISPLAY;
                end
            end
        endcase
    end
    assign Ledr          = frame[LED_HI:LED_LO];
    assign Hex3          = frame[HEX3_LO +: 7] ^ HMASK;
    assign Hex2          = frame[HEX2_LO +: 7] ^ HMASK;
    assign Hex1          = frame[HEX1_LO +: 7] ^ HMASK;
    assign Hex0          = frame[HEX0_LO +: 7] ^ HMASK;
    assign ActiveRoutine = active;
    assign Switching     = sw;
endmodule

// File: tb/tb_routine_bus_sink.sv
// tb_routine_bus_sink: randomized, model-checked bench for routine_bus_sink
module tb_routine_bus_sink;
    localparam int NR = 4;
    localparam int D  = 16;
    localparam int B  = 8;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic              rst_n = 1'b0, tick = 1'b0;
    logic [1:0]        sel = 2'd0, sel2 = 2'd0;
    logic [46*NR-1:0]  bus = '0;
    logic [17:0]       ledr, ledr2;
    logic [6:0]        h3, h2, h1, h0, g3, g2, g1, g0;
    logic [1:0]        act, act2;
    logic              sw, sw2;
    int                checks = 0, errors = 0, first, hi;
    bit                auto_rnd = 1'b0;
    int                m_meta, m_sync, m_act, m_sw, blank_left, pend, cand, age;
    logic [45:0]       m_frame;

    routine_bus_sink dut (
        .Clock(clk), .Reset(rst_n), .RoutineBuses(bus), .SelectIn(sel), .FrameTick(tick),
        .Ledr(ledr), .Hex3(h3), .Hex2(h2), .Hex1(h1), .Hex0(h0),
        .ActiveRoutine(act), .Switching(sw)
    );
    routine_bus_sink #(.NUM_ROUTINES(3), .SEL_W(2), .DEBOUNCE_CYCLES(4), .BLANK_CYCLES(2),
                       .HEX_INVERT(1'b1)) dut2 (
        .Clock(clk), .Reset(rst_n), .RoutineBuses(bus[3*46-1:0]), .SelectIn(sel2), .FrameTick(tick),
        .Ledr(ledr2), .Hex3(g3), .Hex2(g2), .Hex1(g1), .Hex0(g0),
        .ActiveRoutine(act2), .Switching(sw2)
    );

    function automatic logic [45:0] rbus();
        return {14'($urandom), $urandom};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the shown routine only changes after a new valid select has been
    // seen unchanged for D cycles; then the display is dark for B cycles.
    task automatic model_edge();
        int s;
        s = m_sync;
        if (!rst_n) begin
            m_meta = 0; m_sync = 0; m_act = 0; m_sw = 0; m_frame = '0;
            blank_left = 0; pend = 0; cand = 0; age = 0;
            return;
        end
        if (blank_left > 0) begin
            blank_left--;
            if (blank_left == 0) m_sw = 0;
        end else begin
            if (tick) m_frame = bus[m_act*46 +: 46];
            if (!pend) begin
                if (s < NR && s != m_act) begin pend = 1; cand = s; age = 1; end
            end else if (s >= NR || s == m_act) pend = 0;
            else if (s != cand) begin cand = s; age = 1; end
            else if (age == D) begin
                m_act = cand; m_frame = '0; m_sw = 1; blank_left = B; pend = 0;
            end else age++;
        end
        m_sync = m_meta;
        m_meta = int'(sel);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("ledr", ledr, m_frame[45:28]);
        chk("hex", {h3, h2, h1, h0}, m_frame[27:0]);
        chk("active", act, m_act);
        chk("switching", sw, m_sw);
        if (auto_rnd) begin
            tick = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < NR; k++) bus[k*46 +: 46] = rbus();
        end
    endtask

    task automatic run_to_rise(input int limit);
        first = 0;
        for (int i = 1; i <= limit && first == 0; i++) begin
            step();
            if (sw === 1'b1) first = i;
        end
    endtask

    initial begin
        // reset with random traffic
        auto_rnd = 1'b1;
        rst_n = 1'b0;
        repeat (3) step();
        chk("reset_active", act, 0);
        chk("reset_hex_inv", {g3, g2, g1, g0}, {4{7'h7F}});
        // frame latch and hold
        auto_rnd = 1'b0;
        tick = 1'b0;
        rst_n = 1'b1;
        bus[45:0] = 46'h2AAAA0F3F;
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("hex0_bus0", h0, 7'h3F);
        chk("ledr_bus0", ledr, 18'h2A);
        bus[45:0] = rbus();
        repeat (3) step();
        chk("ledr_hold", ledr, 18'h2A);
        // clean switch to routine 2
        auto_rnd = 1'b1;
        sel = 2'd2;
        run_to_rise(40);
        chk("rise_edge", first, 19);
        hi = 1;
        repeat (30) begin step(); hi += int'(sw); end
        chk("blank_len", hi, B);
        chk("active_after", act, 2);
        // back to 0, then a short glitch that must be rejected
        sel = 2'd0;
        repeat (40) step();
        sel = 2'd1;
        repeat (5) step();
        sel = 2'd0;
        hi = 0;
        repeat (40) begin step(); hi += int'(sw); end
        chk("glitch_no_blank", hi, 0);
        chk("glitch_active", act, 0);
        // candidate changes mid-debounce: counter restarts
        sel = 2'd1;
        repeat (8) step();
        sel = 2'd3;
        run_to_rise(40);
        chk("restart_rise", first, 19);
        chk("restart_active", act, 3);
        repeat (20) step();
        // reset during the 4th blank cycle
        sel = 2'd1;
        run_to_rise(40);
        chk("rst_rise", first, 19);
        repeat (3) step();
        rst_n = 1'b0;
        step();
        chk("rst_blank_sw", sw, 0);
        chk("rst_blank_act", act, 0);
        chk("rst_blank_ledr", ledr, 0);
        rst_n = 1'b1;
        repeat (5) step();
        // three-routine, inverted-hex instance
        sel2 = 2'd3;
        hi = 0;
        repeat (30) begin step(); hi += int'(sw2); end
        chk("d2_invalid_no_blank", hi, 0);
        chk("d2_invalid_active", act2, 0);
        sel2 = 2'd2;
        first = 0;
        for (int i = 1; i <= 30 && first == 0; i++) begin
            step();
            if (sw2 === 1'b1) begin
                first = i;
                chk("d2_blank_hex", {g3, g2, g1, g0}, {4{7'h7F}});
                chk("d2_blank_ledr", ledr2, 0);
            end
        end
        chk("d2_rise", first, 7);
        chk("d2_active", act2, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
